ibex_fetch_align_decoder: RTL and testbench
===========================================

IBEX_FETCH_ALIGN_DECODER -- requirements
Module: ibex_fetch_align_decoder

Interface
REQ-001 SHALL have parameter DEPTH, default 2: fetch-word FIFO entries, legal range 2..8.
REQ-002 SHALL have parameter OUT_REG, default 1: 1 = registered output stage, 0 = outputs driven combinationally from FIFO head.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock for the whole block.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port flush_i, input, 1 bit: discard all buffered state and restart at flush_addr_i.
REQ-006 SHALL have port flush_addr_i, input, 32 bits: restart PC, halfword aligned (bit 0 ignored).
REQ-007 SHALL have port fetch_valid_i, input, 1 bit: fetch word valid.
REQ-008 SHALL have port fetch_ready_o, output, 1 bit: FIFO can accept a word.
REQ-009 SHALL have port fetch_rdata_i, input, 32 bits: word-aligned fetch data, little-endian halfwords.
REQ-010 SHALL have port out_valid_o, output, 1 bit: instruction available.
REQ-011 SHALL have port out_ready_i, input, 1 bit: consumer accepts the instruction.
REQ-012 SHALL have port instr_o, output, 32 bits: expanded 32-bit instruction.
REQ-013 SHALL have port instr_raw_o, output, 32 bits: raw bits, upper half zero when compressed.
REQ-014 SHALL have port is_compressed_o, output, 1 bit: raw[1:0] != 2'b11.
REQ-015 SHALL have port illegal_instr_o, output, 1 bit: compressed encoding illegal for RV32C.
REQ-016 SHALL have port pc_o, output, 32 bits: address of the presented instruction.

Function
REQ-017 SHALL push a word when fetch_valid_i && fetch_ready_o && !flush_i; fetch_ready_o = (count < DEPTH), using the registered count only, with no path from out_ready_i.
REQ-018 SHALL keep a halfword offset into the head word; the candidate starts at the offset; 16-bit needs one halfword, 32-bit needs two, possibly spanning head and head+1.
REQ-019 SHALL assert out_valid only when all halfwords of the candidate are buffered; a straddling 32-bit instruction waits for the next word with out_valid low.
REQ-020 SHALL, on out_valid && out_ready, advance PC and offset by 2 (compressed) or 4, and pop each word fully consumed.
REQ-021 SHALL expand compressed instructions to RV32I/M equivalents, with RV32C illegal rules; 32-bit instructions pass unchanged, illegal=0.
REQ-022 SHALL hold all outputs stable while out_valid && !out_ready (AXI-style; valid never drops without acceptance or flush).
REQ-023 SHALL have latency, with OUT_REG=0, of out_valid in the cycle after the completing word is pushed; OUT_REG=1 adds exactly one cycle and sustains one instruction per cycle under continuous out_ready.
REQ-024 SHALL, on flush_i, next cycle: FIFO empty, output stage invalid, PC=flush_addr_i, offset=flush_addr_i[1]; fetch data in the flush cycle is dropped; flush wins over simultaneous push/pop.
REQ-025 SHALL, when offset=1 after flush, discard the low halfword of the first pushed word.
REQ-026 SHALL allow push and pop in the same cycle at full; ready stays low that cycle.
REQ-027 SHALL wrap the PC modulo 2^32 with no error.

Reset
REQ-028 SHALL, on rst_ni low, clear immediately: count=0, pointers=0, offset=0, PC=0, output stage invalid; out_valid_o=0, fetch_ready_o=1 after the first clock, instr_o/instr_raw_o/pc_o=0, is_compressed_o=0, illegal_instr_o=0.
REQ-029 SHALL, on reset mid-operation, discard all buffered words without emitting any partial instruction.

Structure
REQ-030 SHALL place RV32 opcode constants, the compressed-quadrant enum and a DEPTH-derived pointer-width function in package ibex_fetch_align_pkg.
REQ-031 SHALL implement expansion in one purely combinational sub-module, ibex_c_expand (in: 16-bit; out: 32-bit instr, illegal); all state stays in the top.

Verification
REQ-032 SHALL cover: flush to 0x0, push 0x00930505, 0x05050010 -> 0x00150513 @pc 0x0 (C=1); 0x00100093 @pc 0x2 (C=0), only after word 2; 0x00150513 @pc 0x6.
REQ-033 SHALL cover: push 0x00000000 -> illegal_instr_o=1 @pc 0x0 and @pc 0x2.
REQ-034 SHALL cover: flush to 0x102, push 0x05050000 -> single instruction 0x00150513 @pc 0x102.
REQ-035 SHALL cover: DEPTH=2, out_ready_i=0, three words offered -> fetch_ready_o low after two; outputs unchanged for 5 stalled cycles.
REQ-036 SHALL cover: straddling 32-bit pending, then flush_i with addr 0x200 -> out_valid_o low next cycle; next output pc_o=0x200.
REQ-037 SHALL cover: rst_ni low mid-stream for one cycle -> all outputs at reset values immediately, no stale instruction after release.

Source files
------------

// File: rtl/ibex_fetch_align_pkg.sv
// Shared constants and types for the fetch-align/decompress path.
package ibex_fetch_align_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  typedef enum logic [1:0] {
    C_Q0   = 2'b00,
    C_Q1   = 2'b01,
    C_Q2   = 2'b10,
    C_NONE = 2'b11
  } c_quadrant_e;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ibex_c_expand.sv
// Combinational RV32C -> RV32I expander with RV32C illegal-encoding detection.
module ibex_c_expand
  import ibex_fetch_align_pkg::*;
(
  input  logic [15:0] instr_i,
  output logic [31:0] instr_o,
  output logic        illegal_o
);

  logic [2:0] funct3;
  logic [4:0] rd;
  logic [4:0] rs2;
  logic [2:0] rdp;
  logic [2:0] rs2p;

  assign funct3 = instr_i[15:13];
  assign rd     = instr_i[11:7];
  assign rs2    = instr_i[6:2];
  assign rdp    = instr_i[9:7];
  assign rs2p   = instr_i[4:2];

  always_comb begin
    instr_o   = {16'h0, instr_i};
    illegal_o = 1'b0;
    case (c_quadrant_e'(instr_i[1:0]))
      C_Q0: begin
        case (funct3)
          3'b000: begin
            instr_o = {2'b0, instr_i[10:7], instr_i[12:11], instr_i[5], instr_i[6], 2'b00,
                       5'd2, 3'b000, 2'b01, rs2p, OPC_OP_IMM};
            illegal_o = (instr_i[12:5] == 8'h0);
          end
          3'b010: instr_o = {5'b0, instr_i[5], instr_i[12:10], instr_i[6], 2'b00,
                             2'b01, rdp, 3'b010, 2'b01, rs2p, OPC_LOAD};
          3'b110: instr_o = {5'b0, instr_i[5], instr_i[12], 2'b01, rs2p, 2'b01, rdp,
                             3'b010, instr_i[11:10], instr_i[6], 2'b00, OPC_STORE};
          default: illegal_o = 1'b1;
        endcase
      end
      C_Q1: begin
        case (funct3)
          3'b000: instr_o = {{6{instr_i[12]}}, instr_i[12], rs2, rd, 3'b000, rd, OPC_OP_IMM};
          3'b001, 3'b101:
            instr_o = {instr_i[12], instr_i[8], instr_i[10:9], instr_i[6], instr_i[7],
                       instr_i[2], instr_i[11], instr_i[5:3], {9{instr_i[12]}},
                       4'b0, ~instr_i[15], OPC_JAL};
          3'b010: instr_o = {{6{instr_i[12]}}, instr_i[12], rs2, 5'b0, 3'b000, rd, OPC_OP_IMM};
          3'b011: begin
            if (rd == 5'd2)
              instr_o = {{3{instr_i[12]}}, instr_i[4:3], instr_i[5], instr_i[2], instr_i[6],
                         4'b0, 5'd2, 3'b000, 5'd2, OPC_OP_IMM};
            else
              instr_o = {{15{instr_i[12]}}, rs2, rd, OPC_LUI};
            illegal_o = ({instr_i[12], rs2} == 6'h0);
          end
          3'b100: begin
            case (instr_i[11:10])
              2'b00, 2'b01: begin
                instr_o = {1'b0, instr_i[10], 5'b0, rs2, 2'b01, rdp, 3'b101, 2'b01, rdp,
                           OPC_OP_IMM};
                illegal_o = instr_i[12];
              end
              2'b10: instr_o = {{6{instr_i[12]}}, instr_i[12], rs2, 2'b01, rdp, 3'b111,
                                2'b01, rdp, OPC_OP_IMM};
              default: begin
                case ({instr_i[12], instr_i[6:5]})
                  3'b000: instr_o = {7'b0100000, 2'b01, rs2p, 2'b01, rdp, 3'b000, 2'b01, rdp, OPC_OP};
                  3'b001: instr_o = {7'b0, 2'b01, rs2p, 2'b01, rdp, 3'b100, 2'b01, rdp, OPC_OP};
                  3'b010: instr_o = {7'b0, 2'b01, rs2p, 2'b01, rdp, 3'b110, 2'b01, rdp, OPC_OP};
                  3'b011: instr_o = {7'b0, 2'b01, rs2p, 2'b01, rdp, 3'b111, 2'b01, rdp, OPC_OP};
                  default: illegal_o = 1'b1;
                endcase
              end
            endcase
          end
          default:
            instr_o = {{4{instr_i[12]}}, instr_i[6:5], instr_i[2], 5'b0, 2'b01, rdp,
                       2'b00, instr_i[13], instr_i[11:10], instr_i[4:3], instr_i[12], OPC_BRANCH};
        endcase
      end
      C_Q2: begin
        case (funct3)
          3'b000: begin
            instr_o   = {7'b0, rs2, rd, 3'b001, rd, OPC_OP_IMM};
            illegal_o = instr_i[12];
          end
          3'b010: begin
            instr_o   = {4'b0, instr_i[3:2], instr_i[12], instr_i[6:4], 2'b00, 5'd2, 3'b010,
                         rd, OPC_LOAD};
            illegal_o = (rd == 5'd0);
          end
          3'b100: begin
            if (!instr_i[12]) begin
              if (rs2 != 5'd0) begin
                instr_o = {7'b0, rs2, 5'b0, 3'b000, rd, OPC_OP};
              end else begin
                instr_o   = {12'b0, rd, 3'b000, 5'b0, OPC_JALR};
                illegal_o = (rd == 5'd0);
              end
            end else if (rs2 != 5'd0) begin
              instr_o = {7'b0, rs2, rd, 3'b000, rd, OPC_OP};
            end else if (rd == 5'd0) begin
              instr_o = {12'h001, 5'b0, 3'b000, 5'b0, OPC_SYSTEM};
            end else begin
              instr_o = {12'b0, rd, 3'b000, 5'd1, OPC_JALR};
            end
          end
          3'b110: instr_o = {4'b0, instr_i[8:7], instr_i[12], rs2, 5'd2, 3'b010,
                             instr_i[11:9], 2'b00, OPC_STORE};
          default: illegal_o = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ibex_fetch_align_decoder.sv
// Fetch-word FIFO with halfword alignment, RVC expansion and optional output register.
module ibex_fetch_align_decoder
  import ibex_fetch_align_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter bit          OUT_REG = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic [31:0] flush_addr_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_raw_o,
  output logic        is_compressed_o,
  output logic        illegal_instr_o,
  output logic [31:0] pc_o
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_nxt, wr_ptr_nxt;
  logic [CW-1:0] count_q;
  logic          offset_q;
  logic [31:0]   pc_q;

  logic        push, pop, cand_take, cand_valid, cand_c, exp_illegal;
  logic [15:0] cand_lo, cand_hi;
  logic [31:0] head_word, next_word, cand_raw, cand_instr, exp_instr;
  logic        cand_ill;

  assign fetch_ready_o = (count_q < CW'(DEPTH));
  assign push          = fetch_valid_i && fetch_ready_o && !flush_i;
  assign rd_ptr_nxt    = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
  assign wr_ptr_nxt    = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;

  // With offset set, a 32-bit candidate straddles into the following word.
  assign head_word  = mem_q[rd_ptr_q];
  assign next_word  = mem_q[rd_ptr_nxt];
  assign cand_lo    = offset_q ? head_word[31:16] : head_word[15:0];
  assign cand_hi    = offset_q ? next_word[15:0]  : head_word[31:16];
  assign cand_c     = (cand_lo[1:0] != 2'b11);
  assign cand_valid = (count_q != '0) && (cand_c || !offset_q || count_q >= CW'(2));
  assign pop        = cand_take && (offset_q || !cand_c);

  ibex_c_expand u_c_expand (
    .instr_i   (cand_lo),
    .instr_o   (exp_instr),
    .illegal_o (exp_illegal)
  );

  assign cand_raw   = cand_c ? {16'h0, cand_lo} : {cand_hi, cand_lo};
  assign cand_instr = cand_c ? exp_instr : cand_raw;
  assign cand_ill   = cand_c && exp_illegal;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= fetch_rdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      offset_q <= 1'b0;
      pc_q     <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      offset_q <= flush_addr_i[1];
      pc_q     <= flush_addr_i & ~32'h1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_nxt;
      if (pop)  rd_ptr_q <= rd_ptr_nxt;
      count_q <= count_q + CW'(push) - CW'(pop);
      if (cand_take) begin
        offset_q <= offset_q ^ cand_c;
        pc_q     <= pc_q + (cand_c ? 32'd2 : 32'd4);
      end
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic        stage_valid_q, stage_c_q, stage_ill_q;
    logic [31:0] stage_instr_q, stage_raw_q, stage_pc_q;

    assign cand_take = cand_valid && (!stage_valid_q || out_ready_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni || flush_i) begin
        stage_valid_q <= 1'b0;
        stage_c_q     <= 1'b0;
        stage_ill_q   <= 1'b0;
        stage_instr_q <= '0;
        stage_raw_q   <= '0;
        stage_pc_q    <= '0;
      end else if (cand_take) begin
        stage_valid_q <= 1'b1;
        stage_c_q     <= cand_c;
        stage_ill_q   <= cand_ill;
        stage_instr_q <= cand_instr;
        stage_raw_q   <= cand_raw;
        stage_pc_q    <= pc_q;
      end else if (out_ready_i) begin
        stage_valid_q <= 1'b0;
      end
    end

    assign out_valid_o     = stage_valid_q;
    assign instr_o         = stage_instr_q;
    assign instr_raw_o     = stage_raw_q;
    assign is_compressed_o = stage_c_q;
    assign illegal_instr_o = stage_ill_q;
    assign pc_o            = stage_pc_q;
  end else begin : g_out_comb
    assign cand_take       = cand_valid && out_ready_i;
    // Data is zeroed while invalid so stale FIFO contents never show after reset.
    assign out_valid_o     = cand_valid;
    assign instr_o         = cand_valid ? cand_instr : '0;
    assign instr_raw_o     = cand_valid ? cand_raw : '0;
    assign is_compressed_o = cand_valid && cand_c;
    assign illegal_instr_o = cand_valid && cand_ill;
    assign pc_o            = cand_valid ? pc_q : '0;
  end

endmodule

// File: tb/tb_ibex_fetch_align_decoder.sv
// Directed and randomized checks of ibex_fetch_align_decoder against a halfword-stream scoreboard.
module tb_ibex_fetch_align_decoder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic [31:0] flush_addr_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_rdata_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_raw_o;
  logic        is_compressed_o;
  logic        illegal_instr_o;
  logic [31:0] pc_o;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] raw;
    logic [31:0] instr;
    logic        c;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] hq[$];
  logic [31:0] words[$];

  // Known compressed encodings and their RV32 equivalents.
  logic [15:0] ctab_raw [12] = '{16'h0505, 16'h0001, 16'h0000, 16'h4515, 16'h852E, 16'h9002,
                                 16'h4002, 16'h050E, 16'hA001, 16'h2000, 16'h9C01, 16'h4188};
  logic [31:0] ctab_exp [12] = '{32'h00150513, 32'h00000013, 32'h0, 32'h00500513, 32'h00B00533,
                                 32'h00100073, 32'h0, 32'h00351513, 32'h0000006F, 32'h0, 32'h0,
                                 32'h0005A503};
  logic        ctab_ill [12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                                 1'b1, 1'b0};

  ibex_fetch_align_decoder dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .flush_addr_i    (flush_addr_i),
    .fetch_valid_i   (fetch_valid_i),
    .fetch_ready_o   (fetch_ready_o),
    .fetch_rdata_i   (fetch_rdata_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .instr_o         (instr_o),
    .instr_raw_o     (instr_raw_o),
    .is_compressed_o (is_compressed_o),
    .illegal_instr_o (illegal_instr_o),
    .pc_o            (pc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, "_pc"}, pc_o, e.pc);
    chk({tag, "_raw"}, instr_raw_o, e.raw);
    if (!e.ill) chk({tag, "_instr"}, instr_o, e.instr);
    chk({tag, "_c"}, 32'(is_compressed_o), 32'(e.c));
    chk({tag, "_ill"}, 32'(illegal_instr_o), 32'(e.ill));
  endtask

  task automatic do_flush(input logic [31:0] addr);
    flush_i      = 1'b1;
    flush_addr_i = addr;
    tick();
    flush_i      = 1'b0;
    chk("flush_valid_low", 32'(out_valid_o), 32'd0);
  endtask

  task automatic push(input logic [31:0] w);
    int n = 0;
    fetch_valid_i = 1'b1;
    fetch_rdata_i = w;
    while (!fetch_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (!fetch_ready_o) chk("push_timeout", 32'(fetch_ready_o), 32'd1);
    tick();
    fetch_valid_i = 1'b0;
  endtask

  task automatic expect_instr(input string tag, input logic [31:0] pc, input logic [31:0] raw,
                              input logic [31:0] ins, input logic c, input logic ill);
    int   n = 0;
    exp_t e;
    out_ready_i = 1'b1;
    while (!out_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid_o), 32'd1);
    e = '{pc: pc, raw: raw, instr: ins, c: c, ill: ill};
    check_out(tag, e);
    tick();
    out_ready_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_valid_o), 32'd0);
    chk({tag, "_instr"}, instr_o, 32'd0);
    chk({tag, "_raw"}, instr_raw_o, 32'd0);
    chk({tag, "_pc"}, pc_o, 32'd0);
    chk({tag, "_c"}, 32'(is_compressed_o), 32'd0);
    chk({tag, "_ill"}, 32'(illegal_instr_o), 32'd0);
  endtask

  initial begin
    int          acc;
    int          cyc;
    logic [31:0] start, pc, w32;
    int          idx;
    exp_t        e;
    logic        stall_prev;
    logic [31:0] p_pc, p_raw, p_instr;
    logic        p_c, p_ill;

    rst_ni        = 1'b0;
    flush_i       = 1'b0;
    flush_addr_i  = '0;
    fetch_valid_i = 1'b0;
    fetch_rdata_i = '0;
    out_ready_i   = 1'b0;

    #3;
    check_reset_outputs("reset");
    tick();
    chk("reset_ready", 32'(fetch_ready_o), 32'd1);
    rst_ni = 1'b1;
    tick();

    // Mixed stream with a 32-bit instruction straddling two words.
    do_flush(32'h0);
    push(32'h00930505);
    expect_instr("seq_c0", 32'h0, 32'h00000505, 32'h00150513, 1'b1, 1'b0);
    out_ready_i = 1'b1;
    tick();
    tick();
    chk("seq_straddle_wait", 32'(out_valid_o), 32'd0);
    out_ready_i = 1'b0;
    push(32'h05050010);
    expect_instr("seq_i2", 32'h2, 32'h00100093, 32'h00100093, 1'b0, 1'b0);
    expect_instr("seq_c6", 32'h6, 32'h00000505, 32'h00150513, 1'b1, 1'b0);

    // All-zero halfwords are illegal compressed encodings.
    do_flush(32'h0);
    push(32'h00000000);
    expect_instr("ill0", 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    expect_instr("ill2", 32'h2, 32'h0, 32'h0, 1'b1, 1'b1);

    // Odd-halfword restart drops the low half of the first word.
    do_flush(32'h102);
    push(32'h05050000);
    expect_instr("odd", 32'h102, 32'h00000505, 32'h00150513, 1'b1, 1'b0);
    out_ready_i = 1'b1;
    tick();
    tick();
    chk("odd_single", 32'(out_valid_o), 32'd0);
    out_ready_i = 1'b0;

    // Backpressure: only DEPTH words taken, outputs frozen while stalled.
    do_flush(32'h0);
    acc           = 0;
    fetch_valid_i = 1'b1;
    fetch_rdata_i = 32'h00010001;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (fetch_ready_o) acc++;
      tick();
    end
    fetch_valid_i = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd2);
    chk("bp_ready_low", 32'(fetch_ready_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 32'(out_valid_o), 32'd1);
      chk("bp_hold_pc", pc_o, 32'h0);
      chk("bp_hold_instr", instr_o, 32'h00000013);
      chk("bp_hold_raw", instr_raw_o, 32'h00000001);
      tick();
    end

    // Flush while a straddling instruction is pending.
    do_flush(32'h0);
    push(32'h00930505);
    expect_instr("fl_c0", 32'h0, 32'h00000505, 32'h00150513, 1'b1, 1'b0);
    chk("fl_pending", 32'(out_valid_o), 32'd0);
    do_flush(32'h200);
    push(32'h00010001);
    expect_instr("fl_new", 32'h200, 32'h00000001, 32'h00000013, 1'b1, 1'b0);

    // Reset mid-stream.
    do_flush(32'h0);
    push(32'h00010001);
    push(32'h00930505);
    cyc = 0;
    while (!out_valid_o && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("rst_pre_valid", 32'(out_valid_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    chk("rst_mid_ready", 32'(fetch_ready_o), 32'd1);
    tick();
    rst_ni      = 1'b1;
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_no_stale", 32'(out_valid_o), 32'd0);
    end
    out_ready_i = 1'b0;
    push(32'h00010001);
    expect_instr("rst_after", 32'h0, 32'h00000001, 32'h00000013, 1'b1, 1'b0);

    // Randomized instruction streams with random handshakes on both sides.
    for (int r = 0; r < 6; r++) begin
      start = (r == 0) ? 32'hFFFF_FFF8 : (r == 1) ? 32'hFFFF_FFFA : ($urandom & 32'hFFFF_FFFE);
      hq.delete();
      exp_q.delete();
      words.delete();
      pc = start;
      if (start[1]) hq.push_back(16'($urandom));
      for (int k = 0; k < 24; k++) begin
        if ($urandom_range(0, 2) == 0) begin
          w32 = $urandom | 32'h3;
          hq.push_back(w32[15:0]);
          hq.push_back(w32[31:16]);
          e  = '{pc: pc, raw: w32, instr: w32, c: 1'b0, ill: 1'b0};
          pc = pc + 32'd4;
        end else begin
          idx = $urandom_range(0, 11);
          hq.push_back(ctab_raw[idx]);
          e  = '{pc: pc, raw: {16'h0, ctab_raw[idx]}, instr: ctab_exp[idx], c: 1'b1,
                 ill: ctab_ill[idx]};
          pc = pc + 32'd2;
        end
        exp_q.push_back(e);
      end
      if (hq.size() % 2 != 0) hq.push_back(16'h0001);
      for (int k = 0; k < hq.size(); k += 2) words.push_back({hq[k+1], hq[k]});

      do_flush(start);
      idx        = 0;
      cyc        = 0;
      stall_prev = 1'b0;
      while (exp_q.size() != 0 && cyc < 3000) begin
        fetch_valid_i = (idx < words.size()) && ($urandom_range(0, 3) != 0);
        fetch_rdata_i = fetch_valid_i ? words[idx] : $urandom;
        out_ready_i   = ($urandom_range(0, 3) != 0);
        @(negedge clk_i);
        if (stall_prev) begin
          chk("rnd_hold_valid", 32'(out_valid_o), 32'd1);
          chk("rnd_hold_pc", pc_o, p_pc);
          chk("rnd_hold_raw", instr_raw_o, p_raw);
          chk("rnd_hold_instr", instr_o, p_instr);
          chk("rnd_hold_flags", {30'd0, is_compressed_o, illegal_instr_o}, {30'd0, p_c, p_ill});
        end
        if (out_valid_o && out_ready_i) begin
          e = exp_q.pop_front();
          check_out("rnd", e);
        end
        stall_prev = out_valid_o && !out_ready_i;
        p_pc       = pc_o;
        p_raw      = instr_raw_o;
        p_instr    = instr_o;
        p_c        = is_compressed_o;
        p_ill      = illegal_instr_o;
        if (fetch_valid_i && fetch_ready_o) idx++;
        tick();
        cyc++;
        if (exp_q.size() == 0) out_ready_i = 1'b0;
      end
      fetch_valid_i = 1'b0;
      out_ready_i   = 1'b0;
      chk("rnd_drained", 32'(exp_q.size()), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
